// File: rtl/plc_pkg.sv
// Shared types for the PLC repair engine: FSM state encoding and the
// half-select indices used to split {destination, source} tuples.
package plc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    WRITE
  } state_t;

  // Tuple halves: the low half is the primary copy, the high half the replica.
  localparam int SRC = 0;
  localparam int DST = 1;

endpackage

// File: rtl/plc_repair_fifo.sv
// Two-entry FIFO holding pending repair tuples. A push is accepted only when
// the FIFO is not full at the start of the cycle, even if a pop happens too.
module plc_repair_fifo #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/plc_repair.sv
// Write-back repair engine: reads the primary copy of a mismatching tuple and
// rewrites it into the replica, always yielding the cache ports to the host.
module plc_repair
  import plc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WAY_WIDTH  = 4,
  parameter int DATA_SIZE  = 64,
  parameter int READ_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    err_valid,
  output logic                    err_ready,
  input  logic [2*ADDR_WIDTH-1:0] err_addr_tuple,
  input  logic [2*WAY_WIDTH-1:0]  err_way_tuple,
  input  logic                    read_enable_in,
  input  logic                    write_enable_in,
  input  logic [ADDR_WIDTH-1:0]   write_addr_in,
  input  logic [WAY_WIDTH-1:0]    write_way_in,
  input  logic [DATA_SIZE-1:0]    write_data_in,
  output logic                    write_enable_out,
  output logic [ADDR_WIDTH-1:0]   write_addr_out,
  output logic [WAY_WIDTH-1:0]    write_way_out,
  output logic [DATA_SIZE-1:0]    write_data_out,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [WAY_WIDTH-1:0]    rd_way,
  input  logic [DATA_SIZE-1:0]    rd_data,
  output logic                    repair_busy,
  output logic                    repair_done
);

  localparam int TUPLE_W = 2*ADDR_WIDTH + 2*WAY_WIDTH;
  localparam int CNT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  state_t                 state, state_next;
  logic [CNT_W-1:0]       lat_cnt, lat_cnt_next;
  logic [DATA_SIZE-1:0]   repair_data;
  logic [TUPLE_W-1:0]     head;
  logic                   push, pop, full, empty;
  logic                   capture, repair_we, host_idle, hazard, same_loc;
  logic [ADDR_WIDTH-1:0]  src_addr, dst_addr;
  logic [WAY_WIDTH-1:0]   src_way, dst_way;

  assign err_ready = !full;
  assign push      = err_valid && !full;

  plc_repair_fifo #(
    .WIDTH(TUPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({err_way_tuple, err_addr_tuple}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign src_addr = head[SRC*ADDR_WIDTH +: ADDR_WIDTH];
  assign dst_addr = head[DST*ADDR_WIDTH +: ADDR_WIDTH];
  assign src_way  = head[2*ADDR_WIDTH + SRC*WAY_WIDTH +: WAY_WIDTH];
  assign dst_way  = head[2*ADDR_WIDTH + DST*WAY_WIDTH +: WAY_WIDTH];

  assign same_loc  = (src_addr == dst_addr) && (src_way == dst_way);
  assign host_idle = !read_enable_in && !write_enable_in;
  // A host write touching either end of the in-flight tuple invalidates the
  // read data we hold (source) or would be clobbered by our write (destination).
  assign hazard = write_enable_in &&
                  (((write_addr_in == src_addr) && (write_way_in == src_way)) ||
                   ((write_addr_in == dst_addr) && (write_way_in == dst_way)));

  assign rd_addr     = src_addr;
  assign rd_way      = src_way;
  assign repair_busy = (state != IDLE) || !empty;

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    rd_en        = 1'b0;
    repair_we    = 1'b0;
    repair_done  = 1'b0;
    pop          = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (same_loc) begin
            pop         = 1'b1;
            repair_done = 1'b1;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (host_idle) begin
          rd_en        = 1'b1;
          state_next   = WAIT;
          lat_cnt_next = CNT_LOAD;
        end
      end
      WAIT: begin
        if (hazard) begin
          state_next = READ;
        end else if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = WRITE;
        end else begin
          lat_cnt_next = lat_cnt - 1'b1;
        end
      end
      WRITE: begin
        if (hazard) begin
          state_next = READ;
        end else if (!write_enable_in) begin
          repair_we   = 1'b1;
          repair_done = 1'b1;
          pop         = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Nothing leaves the engine while reset is held; the flush owns the cycle.
    if (rst) begin
      rd_en       = 1'b0;
      repair_we   = 1'b0;
      repair_done = 1'b0;
      pop         = 1'b0;
      capture     = 1'b0;
    end
  end

  always_comb begin
    write_enable_out = write_enable_in;
    write_addr_out   = write_addr_in;
    write_way_out    = write_way_in;
    write_data_out   = write_data_in;
    if (!write_enable_in && repair_we) begin
      write_enable_out = 1'b1;
      write_addr_out   = dst_addr;
      write_way_out    = dst_way;
      write_data_out   = repair_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      repair_data <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      if (capture) repair_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_plc_repair.sv
// Bench for plc_repair: a cache memory model plus a queue of pending tuples
// predict every read, repair write and retirement, under directed and random traffic.
module tb_plc_repair;

  localparam int AW = 8;
  localparam int WW = 4;
  localparam int DW = 64;
  localparam int RL = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            err_valid;
  logic            err_ready;
  logic [2*AW-1:0] err_addr_tuple;
  logic [2*WW-1:0] err_way_tuple;
  logic            read_enable_in;
  logic            write_enable_in;
  logic [AW-1:0]   write_addr_in;
  logic [WW-1:0]   write_way_in;
  logic [DW-1:0]   write_data_in;
  logic            write_enable_out;
  logic [AW-1:0]   write_addr_out;
  logic [WW-1:0]   write_way_out;
  logic [DW-1:0]   write_data_out;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [WW-1:0]   rd_way;
  logic [DW-1:0]   rd_data;
  logic            repair_busy;
  logic            repair_done;

  always #5 clk = ~clk;

  plc_repair #(
    .ADDR_WIDTH(AW), .WAY_WIDTH(WW), .DATA_SIZE(DW), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .err_valid(err_valid), .err_ready(err_ready),
    .err_addr_tuple(err_addr_tuple), .err_way_tuple(err_way_tuple),
    .read_enable_in(read_enable_in), .write_enable_in(write_enable_in),
    .write_addr_in(write_addr_in), .write_way_in(write_way_in), .write_data_in(write_data_in),
    .write_enable_out(write_enable_out), .write_addr_out(write_addr_out),
    .write_way_out(write_way_out), .write_data_out(write_data_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_way(rd_way), .rd_data(rd_data),
    .repair_busy(repair_busy), .repair_done(repair_done)
  );

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] da;
    logic [WW-1:0] sw;
    logic [WW-1:0] dw;
  } tup_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_acc   = 0;
  int            n_done  = 0;
  int            n_flush = 0;
  tup_t          q[$];
  logic [DW-1:0] mem [256][16];
  logic [DW-1:0] pipe_val [RL];
  logic          pipe_vld [RL];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    err_valid       = 1'b0;
    err_addr_tuple  = '0;
    err_way_tuple   = '0;
    read_enable_in  = 1'b0;
    write_enable_in = 1'b0;
    write_addr_in   = '0;
    write_way_in    = '0;
    write_data_in   = '0;
  endtask

  // Mid-cycle checks of every output against the queue/memory model.
  task automatic settle();
    logic rep_wr;
    @(negedge clk);
    rep_wr = write_enable_out && !write_enable_in;
    if (rst) begin
      chk("rst_no_repair_wr", rep_wr, 0);
      chk("rst_no_done", repair_done, 0);
      chk("rst_no_rd", rd_en, 0);
    end else begin
      chk("err_ready", err_ready, q.size() < 2);
      chk("busy", repair_busy, q.size() != 0);
      if (write_enable_in) begin
        chk("host_we", write_enable_out, 1);
        chk("host_addr", write_addr_out, write_addr_in);
        chk("host_way", write_way_out, write_way_in);
        chk("host_data", write_data_out, write_data_in);
      end else if (!rep_wr) begin
        chk("pass_addr", write_addr_out, write_addr_in);
        chk("pass_data", write_data_out, write_data_in);
      end
      if (rd_en) begin
        chk("rd_vs_host", read_enable_in || write_enable_in, 0);
        chk("rd_head", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("rd_addr", rd_addr, q[0].sa);
          chk("rd_way", rd_way, q[0].sw);
        end
      end
      if (rep_wr) begin
        chk("wr_done", repair_done, 1);
        chk("wr_head", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("wr_addr", write_addr_out, q[0].da);
          chk("wr_way", write_way_out, q[0].dw);
          chk("wr_data", write_data_out, mem[q[0].sa][q[0].sw]);
        end
      end
      if (repair_done) begin
        chk("done_head", q.size() != 0, 1);
        if (q.size() != 0)
          chk("done_wr", rep_wr, (q[0].sa != q[0].da) || (q[0].sw != q[0].dw));
      end
    end
  endtask

  // Advance the model across the clock edge and return rd_data for the new cycle.
  task automatic advance();
    tup_t          t;
    logic          acc, pop, was_rst, rd_new;
    logic [DW-1:0] rd_val;
    was_rst = rst;
    acc     = err_valid && err_ready;
    pop     = repair_done && (q.size() != 0);
    t.sa    = err_addr_tuple[AW-1:0];
    t.da    = err_addr_tuple[2*AW-1:AW];
    t.sw    = err_way_tuple[WW-1:0];
    t.dw    = err_way_tuple[2*WW-1:WW];
    rd_new  = rd_en && (q.size() != 0);
    rd_val  = rd_new ? mem[q[0].sa][q[0].sw] : '0;
    if (!was_rst) begin
      if (write_enable_in) mem[write_addr_in][write_way_in] = write_data_in;
      else if (write_enable_out && q.size() != 0) mem[q[0].da][q[0].dw] = mem[q[0].sa][q[0].sw];
    end
    @(posedge clk);
    if (was_rst) begin
      n_flush += q.size();
      q.delete();
      for (int i = 0; i < RL; i++) pipe_vld[i] = 1'b0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        n_done++;
      end
      if (acc) begin
        q.push_back(t);
        n_acc++;
      end
      for (int i = RL-1; i > 0; i--) begin
        pipe_val[i] = pipe_val[i-1];
        pipe_vld[i] = pipe_vld[i-1];
      end
      pipe_val[0] = rd_val;
      pipe_vld[0] = rd_new;
    end
    #1;
    rd_data = pipe_vld[RL-1] ? pipe_val[RL-1] : {$urandom, $urandom};
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    idle_inputs();
    while ((repair_busy || q.size() != 0) && k < budget) begin
      settle();
      advance();
      k++;
    end
    chk("drain_in_budget", k < budget, 1);
  endtask

  // One tuple pushed at c=0, optional host read window and one host write.
  task automatic run_tuple(input logic [AW-1:0] sa, input logic [AW-1:0] da,
                           input logic [WW-1:0] sw, input logic [WW-1:0] dw,
                           input int rd_lo, input int rd_hi, input int hz_cyc,
                           input logic [AW-1:0] hz_addr, input logic [WW-1:0] hz_way,
                           input logic [DW-1:0] hz_data, input int ncyc,
                           output int first_rd, output int first_wr, output int first_done,
                           output int n_rd, output int n_dn, output logic [DW-1:0] wr_data);
    first_rd = -1; first_wr = -1; first_done = -1; n_rd = 0; n_dn = 0; wr_data = '0;
    for (int c = 0; c <= ncyc; c++) begin
      err_valid       = (c == 0);
      err_addr_tuple  = {da, sa};
      err_way_tuple   = {dw, sw};
      read_enable_in  = (c >= rd_lo) && (c <= rd_hi);
      write_enable_in = (c == hz_cyc);
      write_addr_in   = hz_addr;
      write_way_in    = hz_way;
      write_data_in   = hz_data;
      settle();
      if (rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
      end
      if (write_enable_out && !write_enable_in && first_wr < 0) begin
        first_wr = c;
        wr_data  = write_data_out;
      end
      if (repair_done) begin
        n_dn++;
        if (first_done < 0) first_done = c;
      end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int            f_rd, f_wr, f_dn, nr, nd, acc_c, d0, nrep;
    logic [DW-1:0] wd;
    for (int a = 0; a < 256; a++)
      for (int w = 0; w < 16; w++) mem[a][w] = {$urandom, $urandom};
    for (int i = 0; i < RL; i++) pipe_vld[i] = 1'b0;
    idle_inputs();
    rd_data = '0;
    rst = 1'b1;
    repeat (2) begin settle(); advance(); end
    rst = 1'b0;

    settle();
    chk("reset_err_ready", err_ready, 1);
    chk("reset_busy", repair_busy, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_done", repair_done, 0);
    chk("reset_we_out", write_enable_out, 0);
    advance();

    // Basic repair, best-case timing.
    mem[8'h34][4'h5] = 64'hDEAD_BEEF;
    run_tuple(8'h34, 8'h12, 4'h5, 4'h2, -1, -2, -1, 8'h00, 4'h0, '0, 6, f_rd, f_wr, f_dn, nr, nd, wd);
    chk("t1_first_rd", f_rd, 2);
    chk("t1_first_wr", f_wr, 4);
    chk("t1_done_cyc", f_dn, 4);
    chk("t1_wr_data", wd, 64'hDEAD_BEEF);
    chk("t1_n_done", nd, 1);

    // Host reads hold off the repair read.
    mem[8'h34][4'h5] = 64'hCAFE_F00D_0BAD_1DEA;
    run_tuple(8'h34, 8'h12, 4'h5, 4'h2, 2, 4, -1, 8'h00, 4'h0, '0, 9, f_rd, f_wr, f_dn, nr, nd, wd);
    chk("t2_first_rd", f_rd, 5);
    chk("t2_first_wr", f_wr, 7);
    chk("t2_wr_data", wd, 64'hCAFE_F00D_0BAD_1DEA);

    // Host write to destination during WAIT forces a re-read.
    mem[8'h34][4'h5] = 64'h0123_4567_89AB_CDEF;
    run_tuple(8'h34, 8'h12, 4'h5, 4'h2, -1, -2, 3, 8'h12, 4'h2, 64'h1111, 9, f_rd, f_wr, f_dn, nr, nd, wd);
    chk("t3_n_rd", nr, 2);
    chk("t3_first_wr", f_wr, 6);
    chk("t3_n_done", nd, 1);
    chk("t3_wr_data", wd, 64'h0123_4567_89AB_CDEF);

    // Host write to source during WAIT: the re-read must deliver the new value.
    run_tuple(8'h34, 8'h12, 4'h5, 4'h2, -1, -2, 3, 8'h34, 4'h5, 64'hFEED_FACE_0000_0001, 9,
              f_rd, f_wr, f_dn, nr, nd, wd);
    chk("t3b_first_wr", f_wr, 6);
    chk("t3b_fresh_data", wd, 64'hFEED_FACE_0000_0001);

    // Source equals destination: retire without touching the cache.
    run_tuple(8'h40, 8'h40, 4'h1, 4'h1, -1, -2, -1, 8'h00, 4'h0, '0, 3, f_rd, f_wr, f_dn, nr, nd, wd);
    chk("t5_done_cyc", f_dn, 1);
    chk("t5_no_rd", f_rd, -1);
    chk("t5_no_wr", f_wr, -1);

    // Three back-to-back errors against a two-entry queue.
    acc_c = -1;
    d0    = n_done;
    for (int c = 0; c < 30 && acc_c < 0; c++) begin
      err_valid      = 1'b1;
      err_addr_tuple = (c == 0) ? {8'h21, 8'h20} : (c == 1) ? {8'h31, 8'h30} : {8'h41, 8'h42};
      err_way_tuple  = (c == 0) ? {4'h1, 4'h0}   : (c == 1) ? {4'h3, 4'h2}   : {4'h5, 4'h4};
      settle();
      if (c == 2) chk("t4_full_ready", err_ready, 0);
      if (c >= 2 && err_ready) acc_c = c;
      advance();
    end
    chk("t4_accept_cyc", acc_c, 5);
    drain(100);
    chk("t4_retired", n_done - d0, 3);

    // Reset while WRITE is held off by a host write.
    nrep = 0;
    for (int c = 0; c <= 7; c++) begin
      idle_inputs();
      err_valid       = (c == 0);
      err_addr_tuple  = {8'h56, 8'h78};
      err_way_tuple   = {4'h3, 4'h4};
      write_enable_in = (c == 4) || (c == 5);
      write_addr_in   = 8'hAA;
      write_way_in    = 4'hF;
      write_data_in   = 64'h5555;
      rst             = (c == 5);
      settle();
      if (c == 4) begin
        chk("t6_busy_in_write", repair_busy, 1);
        chk("t6_held", repair_done, 0);
      end
      if (c == 5) chk("t6_rst_host_addr", write_addr_out, 8'hAA);
      if (c >= 5 && write_enable_out && !write_enable_in) nrep++;
      if (c == 6) begin
        chk("t6_err_ready", err_ready, 1);
        chk("t6_busy", repair_busy, 0);
      end
      advance();
    end
    rst = 1'b0;
    chk("t6_no_repair_wr", nrep, 0);

    // Random traffic over a small address set so hazards and collisions are common.
    for (int i = 0; i < 2500; i++) begin
      logic [AW-1:0] sa, da;
      logic [WW-1:0] sw, dw;
      sa = AW'($urandom_range(3));
      da = AW'($urandom_range(3));
      sw = WW'($urandom_range(1));
      dw = WW'($urandom_range(1));
      if ($urandom_range(4) == 0) begin
        da = sa;
        dw = sw;
      end
      err_valid       = ($urandom_range(3) == 0);
      err_addr_tuple  = {da, sa};
      err_way_tuple   = {dw, sw};
      read_enable_in  = ($urandom_range(2) == 0);
      write_enable_in = ($urandom_range(4) == 0);
      write_addr_in   = AW'($urandom_range(3));
      write_way_in    = WW'($urandom_range(1));
      write_data_in   = {$urandom, $urandom};
      settle();
      advance();
    end
    drain(300);
    chk("all_retired", n_done, n_acc - n_flush);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plc_repair.md
# plc_repair

Write-back repair engine for the PLC cache checker. It is the write-side counterpart to the read-only check path. It accepts mismatching address/way tuples from the checker and reads the primary copy (tuple element 0). It then rewrites that data into the replica (tuple element 1). It sits beside the read-port mux on the dcache write port, and host traffic always has priority over its accesses.

## Interface
- ADDR_WIDTH, 8, cache index width
- WAY_WIDTH, 4, way-select width
- DATA_SIZE, 64, cache data width
- READ_LAT, 1, cycles from rd_en to valid rd_data (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- err_valid  in  1  checker presents a mismatching tuple
- err_ready  out  1  queue not full
- err_addr_tuple  in  2*ADDR_WIDTH  [ADDR_WIDTH-1:0] = source (primary), upper half = destination (replica)
- err_way_tuple  in  2*WAY_WIDTH  same split as addr
- read_enable_in  in  1  host read this cycle
- write_enable_in  in  1  host write this cycle
- write_addr_in / write_way_in / write_data_in  in  ADDR_WIDTH / WAY_WIDTH / DATA_SIZE  host write
- write_enable_out / write_addr_out / write_way_out / write_data_out  out  1 / ADDR_WIDTH / WAY_WIDTH / DATA_SIZE  muxed cache write port
- rd_en  out  1  repair read request
- rd_addr / rd_way  out  ADDR_WIDTH / WAY_WIDTH  repair read location
- rd_data  in  DATA_SIZE  cache read data
- repair_busy  out  1  state ≠ IDLE or queue non-empty
- repair_done  out  1  one-cycle pulse per retired tuple

## Operation
- Queue: 2-entry FIFO of {addr_tuple, way_tuple}.
  - Push on err_valid & err_ready.
  - err_ready = !full.
  - Pop only on retire.
- Host idle ⇔ !read_enable_in & !write_enable_in.
- FSM states: IDLE, READ, WAIT, WRITE.
- IDLE:
  - Queue non-empty and source == destination (addr and way) → pop and pulse repair_done; no cache access.
  - Queue non-empty, otherwise → READ.
- READ:
  - rd_en = host idle; rd_addr/rd_way = head source.
  - When rd_en is issued → WAIT with latency counter = READ_LAT-1.
  - Host busy → remain in READ (retry every cycle).
- WAIT:
  - Count down the latency counter.
  - At counter == 0, capture rd_data into the repair data register on that edge → WRITE.
- WRITE:
  - When !write_enable_in: drive write_*_out with the head destination and captured data, assert repair_done, pop → IDLE.
  - Host write pending → hold.
- Output mux:
  - write_*_out = host inputs whenever write_enable_in = 1.
  - Otherwise they carry the repair write when one is issued.
  - Otherwise write_enable_out = 0 and address/way/data pass through from the host inputs.
- Hazard abort: in WAIT or WRITE, a host write (write_enable_in) whose addr+way equals the head source or destination sends the FSM → READ next cycle. The tuple is not popped, and the captured data is discarded.
- rd_en is never asserted in the same cycle as a host access. write_enable_out from repair is never asserted alongside a host write.

## Timing
- Reset values:
  - FIFO empty, state IDLE, counter 0, data register 0.
  - err_ready = 1, rd_en = 0, write_enable_out = host passthrough (0 when host idle).
  - repair_busy = 0, repair_done = 0.
- rd_en, repair_done and the write mux are combinational from state and host inputs. All state changes are registered.
- Best case, push at edge of cycle T (READ_LAT = 1):
  - T+1: IDLE sees non-empty queue.
  - T+2: READ, rd_en = 1.
  - T+3: WAIT, rd_data captured.
  - T+4: WRITE, write_enable_out = 1, repair_done = 1.
  - T+5: IDLE.
- General best-case latency from push to done: 3 + READ_LAT cycles.
- Simultaneous push and pop on a full queue: err_ready reflects the pre-pop full state, so the push is not accepted that cycle.
- rst asserted mid-repair: no write is issued in the reset cycle; the queue is flushed and the in-flight tuple is lost.

## Structure
- Shared package plc_pkg:
  - State enum {IDLE, READ, WAIT, WRITE}.
  - Tuple field-split helper constants (SRC = low half, DST = high half).
- Sub-module plc_repair_fifo: parameterized 2-entry FIFO (width 2*ADDR_WIDTH + 2*WAY_WIDTH) with push/pop/full/empty.

## Test plan
- Single error, addr tuple {0x12,0x34}, way tuple {0x2,0x5}, read data 0xDEAD_BEEF: rd_en with addr 0x34/way 0x5 at T+2, then write of 0xDEAD_BEEF to 0x12/way 0x2 at T+4, done at T+4.
- Host read held high cycles T+2..T+4 → rd_en first asserted at T+5 and write at T+7; rd_en never overlaps read_enable_in.
- Host write to addr 0x12/way 0x2 during WAIT → FSM returns to READ and re-reads; the final write carries the fresh rd_data; exactly one repair_done.
- Three back-to-back err_valid pulses: first two accepted, err_ready = 0 on the third until the first pop; all three retire in order.
- Tuple source == destination {0x40,0x40}, way {0x1,0x1} → repair_done at T+1 with no rd_en and no write_enable_out.
- rst asserted in the WRITE state with a host write pending → no repair write, err_ready = 1 and repair_busy = 0 after reset.
